// File: rtl/stream_pkg.sv
// Shared types and default widths for the stream arbitration multiplexer.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DEF_N   = 32;
  localparam int DEF_NCH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search starting at ptr, or fixed
// priority from channel 0 when rr is low. Produces one-hot grant and index.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  input  logic           rr,
  output logic [NCH-1:0] grant,
  output logic [SW-1:0]  idx
);

  // First requester found walking upward from the start point, wrapping at NCH-1.
  always_comb begin
    int   start;
    int   c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    start = rr ? int'(ptr) : 0;
    for (int i = 0; i < NCH; i++) begin
      c = (start + i) % NCH;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-aware NCH-to-1 stream multiplexer with a one-deep registered output.
// A grant is held from a packet's first beat through its last beat.
module stream_arb_mux
  import stream_pkg::*;
#(
  parameter int  N   = DEF_N,
  parameter int  NCH = DEF_NCH,
  parameter int  RR  = 1,
  localparam int SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*N-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH-1:0]   in_last,
  output logic [NCH-1:0]   in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  state_t         state, state_nxt;
  logic [SW-1:0]  gch;
  logic [SW-1:0]  ptr, ptr_nxt;
  logic [SW-1:0]  sel;
  logic [SW-1:0]  arb_idx;
  logic [NCH-1:0] arb_grant;
  logic           load_en;
  logic           sel_valid;
  logic           accept;

  rr_arbiter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .rr    (RR != 0),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign load_en = !out_valid || out_ready;

  // While locked, the held channel is the only candidate, even if it stalls.
  always_comb begin
    state_nxt = state;
    sel       = arb_idx;
    sel_valid = |in_valid;
    in_ready  = '0;
    if (state == LOCK) begin
      sel       = gch;
      sel_valid = in_valid[gch];
    end
    if (rst_n && load_en) begin
      if (state == LOCK) in_ready[gch] = 1'b1;
      else               in_ready      = arb_grant;
    end
    accept = load_en && sel_valid;
    case (state)
      IDLE:    if (accept && !in_last[sel]) state_nxt = LOCK;
      LOCK:    if (accept &&  in_last[sel]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt = ptr;
    if (RR != 0 && accept && in_last[sel])
      ptr_nxt = (int'(sel) == NCH - 1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gch   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (state == IDLE && accept) gch <= sel;
    end
  end

  // Payload fields only change on a real load, so they stay put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= in_data[sel*N +: N];
        out_last <= in_last[sel];
        out_sel  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed and randomised checks of stream_arb_mux (round-robin instance plus
// a fixed-priority instance driven by the same stimulus).
module tb_stream_arb_mux;

  localparam int N    = 32;
  localparam int NCH  = 4;
  localparam int SW   = 2;
  localparam int MAXB = 10100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH*N-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_last;
  logic             out_ready;

  logic [NCH-1:0]   in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_last;
  logic [SW-1:0]    out_sel;

  logic [NCH-1:0]   fp_in_ready;
  logic [N-1:0]     fp_out_data;
  logic             fp_out_valid;
  logic             fp_out_last;
  logic [SW-1:0]    fp_out_sel;

  int tests = 0;
  int fails = 0;

  int  sent [NCH];
  int  rcv  [NCH];
  bit  lastTable [NCH][MAXB];
  bit  openPkt;
  int  openCh;
  bit  prevStall;
  logic [N-1:0]  prevData;
  logic [SW-1:0] prevSel;
  logic          prevLast;

  always #5 clk = ~clk;

  stream_arb_mux #(.N(N), .NCH(NCH), .RR(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  stream_arb_mux #(.N(N), .NCH(NCH), .RR(0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_valid (fp_out_valid),
    .out_last  (fp_out_last),
    .out_sel   (fp_out_sel),
    .out_ready (out_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [SW-1:0] s, input logic [N-1:0] d,
                           input logic l);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    checkOutput({tag, "_sel"},   64'(out_sel),   64'(s));
    checkOutput({tag, "_data"},  64'(out_data),  64'(d));
    checkOutput({tag, "_last"},  64'(out_last),  64'(l));
  endtask

  task automatic setData(input int c, input logic [N-1:0] v);
    in_data[c*N +: N] = v;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH-1:0] l, input logic ordy);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one output transfer against the per-channel beat numbering.
  task automatic checkTransfer();
    int c;
    c = int'(out_sel);
    checkOutput("rnd_avail", 64'(rcv[c] < sent[c]), 64'(1));
    if (rcv[c] < sent[c]) begin
      checkOutput("rnd_data", 64'(out_data), 64'({4'(c), 28'(rcv[c])}));
      checkOutput("rnd_last", 64'(out_last), 64'(lastTable[c][rcv[c]]));
    end
    if (openPkt) checkOutput("rnd_interleave", 64'(c), 64'(openCh));
    rcv[c]++;
    openPkt = !out_last;
    openCh  = c;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    #2;
    checkOutput("rst_in_ready",  64'(in_ready),  64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data",  64'(out_data),  64'(0));

    // Round-robin over single-beat packets, one beat per cycle.
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) setData(c, 32'hA000_0000 + 32'(c));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkOutput("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (i % 4)));
      tick();
      checkBeat("rr_beat", SW'(i % 4), 32'hA000_0000 + 32'(i % 4), 1'b1);
    end

    // Packet lock on ch1 with ch0 waiting; a mid-packet stall holds the grant.
    setData(1, 32'hB000_0000);
    setData(0, 32'hC000_0000);
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    checkOutput("lock_in_ready0", 64'(in_ready), 64'(4'b0010));
    tick();
    checkBeat("lock_b0", 2'd1, 32'hB000_0000, 1'b0);
    setData(1, 32'hB000_0001);
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    checkOutput("lock_in_ready1", 64'(in_ready), 64'(4'b0010));
    tick();
    checkBeat("lock_b1", 2'd1, 32'hB000_0001, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("lock_stall_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    checkOutput("lock_stall_valid", 64'(out_valid), 64'(0));
    setData(1, 32'hB000_0002);
    applyStimulus(4'b0011, 4'b0010, 1'b1);
    checkOutput("lock_in_ready2", 64'(in_ready), 64'(4'b0010));
    tick();
    checkBeat("lock_b2", 2'd1, 32'hB000_0002, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("ch0_in_ready0", 64'(in_ready), 64'(4'b0001));
    tick();
    checkBeat("ch0_b0", 2'd0, 32'hC000_0000, 1'b0);
    setData(0, 32'hC000_0001);
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    tick();
    checkBeat("ch0_b1", 2'd0, 32'hC000_0001, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("idle_valid", 64'(out_valid), 64'(0));

    // Backpressure: the held beat must not change and nothing is accepted.
    setData(2, 32'hDEAD_BEEF);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    checkOutput("bp_first_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    checkBeat("bp_load", 2'd2, 32'hDEAD_BEEF, 1'b1);
    setData(2, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, 4'b0100, 1'b0);
      checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
      tick();
      checkBeat("bp_hold", 2'd2, 32'hDEAD_BEEF, 1'b1);
    end
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    checkOutput("bp_release_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    checkBeat("bp_next", 2'd2, 32'h1234_5678, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("bp_drained", 64'(out_valid), 64'(0));

    // Reset in the middle of a ch2 packet.
    setData(2, 32'h2222_0000);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    tick();
    checkBeat("mid_pkt", 2'd2, 32'h2222_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid",    64'(out_valid), 64'(0));
    checkOutput("mrst_data",     64'(out_data),  64'(0));
    checkOutput("mrst_sel",      64'(out_sel),   64'(0));
    checkOutput("mrst_last",     64'(out_last),  64'(0));
    checkOutput("mrst_in_ready", 64'(in_ready),  64'(0));
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) setData(c, 32'h5000_0000 + 32'(c));
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkOutput("post_rst_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    checkBeat("post_rst_beat", 2'd0, 32'h5000_0000, 1'b1);

    // Fixed priority instance: ch1 beats ch3 while ch1 stays valid.
    setData(1, 32'hF000_0001);
    setData(3, 32'hF000_0003);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1010, 4'b1111, 1'b1);
      checkOutput("fp_in_ready", 64'(fp_in_ready), 64'(4'b0010));
      tick();
      checkOutput("fp_sel",  64'(fp_out_sel),  64'(1));
      checkOutput("fp_data", 64'(fp_out_data), 64'(32'hF000_0001));
    end
    applyStimulus(4'b1000, 4'b1111, 1'b1);
    tick();
    checkOutput("fp_sel_ch3", 64'(fp_out_sel), 64'(3));

    // Randomised traffic scored by per-channel beat numbering.
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      sent[c] = 0;
      rcv[c]  = 0;
      for (int k = 0; k < MAXB; k++) lastTable[c][k] = ($urandom_range(0, 3) == 0);
    end
    openPkt   = 1'b0;
    openCh    = 0;
    prevStall = 1'b0;
    prevData  = '0;
    prevSel   = '0;
    prevLast  = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        in_valid[c] = ($urandom_range(0, 9) < 7);
        in_last[c]  = lastTable[c][sent[c]];
        setData(c, {4'(c), 28'(sent[c])});
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #3;
      if (prevStall) begin
        checkOutput("rnd_hold_valid", 64'(out_valid), 64'(1));
        checkOutput("rnd_hold_data",  64'(out_data),  64'(prevData));
        checkOutput("rnd_hold_sel",   64'(out_sel),   64'(prevSel));
        checkOutput("rnd_hold_last",  64'(out_last),  64'(prevLast));
      end
      checkOutput("rnd_onehot", 64'($countones(in_ready) <= 1), 64'(1));
      if (out_valid && out_ready) checkTransfer();
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevSel   = out_sel;
      prevLast  = out_last;
      for (int c = 0; c < NCH; c++)
        if (in_valid[c] && in_ready[c]) sent[c]++;
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3;
      if (out_valid && out_ready) checkTransfer();
      tick();
    end
    for (int c = 0; c < NCH; c++) checkOutput("rnd_count", 64'(rcv[c]), 64'(sent[c]));
    checkOutput("rnd_final_valid", 64'(out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
